// File: rtl/mesh_sched_pkg.sv
`default_nettype none
// ============================================================================
// Package : mesh_sched_pkg
// Brief   : Shared types, constants and the round-robin scan helper for the
//           mesh terminal pop scheduler.
// Rev     : 1.0  initial release
// ============================================================================
package mesh_sched_pkg;

    // Width of the optional statistics counters.
    localparam int STAT_W = 32;

    // Largest terminal count the scan helper handles. The request vector is
    // zero-padded to this width, so scanning to the top and wrapping gives the
    // same answer as wrapping at the real terminal count.
    localparam int RR_MAXN = 64;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_WAIT = 2'd2
    } sched_state_t;

    // Index of the first set bit scanning ptr, ptr+1, ... with wrap; -1 if none.
    function automatic int rr_first(input logic [RR_MAXN-1:0] pend, input int ptr);
        int res;
        int idx;
        res = -1;
        // Walk the scan order backwards so the earliest hit overwrites later ones.
        for (int k = RR_MAXN - 1; k >= 0; k--) begin
            idx = (ptr + k) % RR_MAXN;
            if (pend[idx]) begin
                res = idx;
            end
        end
        return res;
    endfunction

endpackage : mesh_sched_pkg
`default_nettype wire

// File: rtl/mesh_term_pop_scheduler_if.sv
`default_nettype none
// ============================================================================
// Interface : mesh_term_pop_scheduler_if
// Brief     : Terminal-side (pndng/data_out/pop) and sink-side (valid/ready)
//             signals of the mesh terminal pop scheduler.
//             Optional counters appear when MESH_SCHED_STATS_EN is defined.
// Rev       : 1.0  initial release
// ============================================================================
interface mesh_term_pop_scheduler_if
    import mesh_sched_pkg::*;
#(
    parameter int NTERM   = 16,
    parameter int pckg_sz = 40,
    parameter int IDW     = 4
) ();

    logic [NTERM-1:0]              pndng;
    logic [NTERM-1:0][pckg_sz-1:0] data_out;
    logic [NTERM-1:0]              pop;
    logic                          out_valid;
    logic                          out_ready;
    logic [pckg_sz-1:0]            out_data;
    logic [IDW-1:0]                out_src;
    logic                          busy;
`ifdef MESH_SCHED_STATS_EN
    logic [STAT_W-1:0]             stat_pops;
    logic [STAT_W-1:0]             stat_stall;

    modport master (
        input  pndng, data_out, out_ready,
        output pop, out_valid, out_data, out_src, busy, stat_pops, stat_stall
    );
    modport slave (
        output pndng, data_out, out_ready,
        input  pop, out_valid, out_data, out_src, busy, stat_pops, stat_stall
    );
`else
    modport master (
        input  pndng, data_out, out_ready,
        output pop, out_valid, out_data, out_src, busy
    );
    modport slave (
        output pndng, data_out, out_ready,
        input  pop, out_valid, out_data, out_src, busy
    );
`endif

endinterface : mesh_term_pop_scheduler_if
`default_nettype wire

// File: rtl/mesh_rr_picker.sv
`default_nettype none
// ============================================================================
// Module : mesh_rr_picker
// Brief  : Combinational round-robin picker: first requester at or after ptr,
//          wrapping past the last terminal.
// Rev    : 1.0  initial release
// ============================================================================
module mesh_rr_picker
    import mesh_sched_pkg::*;
#(
    parameter int NTERM = 16,
    parameter int IDW   = 4
) (
    input  logic [NTERM-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic             gnt_vld,
    output logic [IDW-1:0]   gnt_idx
);

    logic [RR_MAXN-1:0] req_ext;
    int                 scan_hit;

    // Pad the request vector and run the wrapping scan from ptr.
    always_comb begin
        req_ext              = '0;
        req_ext[NTERM-1:0]   = req;
        scan_hit             = rr_first(req_ext, int'(ptr));
        gnt_vld              = |req;
        gnt_idx              = (scan_hit < 0) ? '0 : IDW'(scan_hit);
    end

endmodule : mesh_rr_picker
`default_nettype wire

// File: rtl/mesh_term_pop_scheduler.sv
`default_nettype none
// ============================================================================
// Module : mesh_term_pop_scheduler
// Brief  : Drains the mesh edge terminals into one tagged stream. Round-robin
//          grant, one registered pop pulse per grant, then a dead cycle so the
//          terminal's show-ahead head can settle.
//          Define MESH_SCHED_STATS_EN to add grant / stall counters.
// Rev    : 1.0  initial release
// ============================================================================
module mesh_term_pop_scheduler
    import mesh_sched_pkg::*;
#(
    parameter int ROWS    = 4,
    parameter int COLUMS  = 4,
    parameter int pckg_sz = 40
) (
    input  logic                          clk,
    input  logic                          reset,
    mesh_term_pop_scheduler_if.master     bus
);

    localparam int NTERM = ROWS * 2 + COLUMS * 2;
    localparam int IDW   = $clog2(NTERM);

    sched_state_t       state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NTERM-1:0]   pop_q, pop_d;
    logic               out_valid_q, out_valid_d;
    logic [pckg_sz-1:0] out_data_q, out_data_d;
    logic [IDW-1:0]     out_src_q, out_src_d;

    logic               gnt_vld;
    logic [IDW-1:0]     gnt_idx;
    logic               grant;
    logic               accept;

    mesh_rr_picker #(
        .NTERM (NTERM),
        .IDW   (IDW)
    ) u_picker (
        .req     (bus.pndng),
        .ptr     (rr_ptr_q),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    // Next-state: grant in IDLE, then POP, then the settle cycle; output register alongside.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        pop_d       = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        accept      = out_valid_q & bus.out_ready;
        grant       = (state_q == S_IDLE) & gnt_vld & (~out_valid_q | bus.out_ready);

        if (accept) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                // A capture overrides the accept-clear so back-to-back packets have no bubble.
                if (grant) begin
                    out_valid_d    = 1'b1;
                    out_data_d     = bus.data_out[gnt_idx];
                    out_src_d      = gnt_idx;
                    pop_d[gnt_idx] = 1'b1;
                    rr_ptr_d       = (gnt_idx == IDW'(NTERM - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d        = S_POP;
                end
            end
            S_POP:   state_d = S_WAIT;
            S_WAIT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset takes effect immediately, dropping any held packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            pop_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            pop_q       <= pop_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign bus.pop       = pop_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.busy      = (state_q != S_IDLE);

`ifdef MESH_SCHED_STATS_EN
    logic [STAT_W-1:0] stat_pops_q, stat_pops_d;
    logic [STAT_W-1:0] stat_stall_q, stat_stall_d;

    // Saturating counters: grants, and cycles where work waits behind a stalled sink.
    always_comb begin
        stat_pops_d  = stat_pops_q;
        stat_stall_d = stat_stall_q;
        if (grant && (stat_pops_q != '1)) begin
            stat_pops_d = stat_pops_q + 1'b1;
        end
        if ((|bus.pndng) && out_valid_q && !bus.out_ready && (stat_stall_q != '1)) begin
            stat_stall_d = stat_stall_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_pops_q  <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_pops_q  <= stat_pops_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign bus.stat_pops  = stat_pops_q;
    assign bus.stat_stall = stat_stall_q;
`endif

    // The granted terminal must keep its packet pending while it is being popped.
    a_pndng_held_in_pop: assert property (@(posedge clk) disable iff (reset)
        (state_q == S_POP) |-> bus.pndng[out_src_q]);

    // Never more than one terminal popped in a cycle.
    a_pop_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(pop_q));

endmodule : mesh_term_pop_scheduler
`default_nettype wire

// File: tb/tb_mesh_term_pop_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_mesh_term_pop_scheduler
// Brief  : Directed self-checking bench for mesh_term_pop_scheduler with a
//          queue-per-terminal model of the show-ahead mesh terminals.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mesh_term_pop_scheduler;

    localparam int NT = 16;
    localparam int PW = 40;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mesh_term_pop_scheduler_if #(.NTERM(NT), .pckg_sz(PW), .IDW(IW)) bus ();

    mesh_term_pop_scheduler #(
        .ROWS    (4),
        .COLUMS  (4),
        .pckg_sz (PW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Load log written by the stimulus, consumed by the terminal model.
    int            ld_n = 0;
    int            ld_term [256];
    logic [PW-1:0] ld_data [256];

    task automatic load(input int t, input logic [PW-1:0] d);
        ld_term[ld_n] = t;
        ld_data[ld_n] = d;
        ld_n++;
    endtask

    // Terminal model and stream monitor state.
    logic [PW-1:0]    termq [NT][$];
    logic [IW+PW-1:0] acc_q [$];
    int               pop_cnt [NT];
    int               rd_n      = 0;
    int               multi_hot = 0;
    int               dbl_pop   = 0;
    logic [NT-1:0]    pend_pop  = '0;
    logic [NT-1:0]    prev_pop  = '0;

    // Terminals update on the negedge; a pop seen during POP is applied one cycle later (WAIT).
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                for (int i = 0; i < NT; i++) begin
                    termq[i].delete();
                    pop_cnt[i] = 0;
                end
                rd_n     = ld_n;
                pend_pop = '0;
                prev_pop = '0;
                acc_q.delete();
            end else begin
                for (int i = 0; i < NT; i++) begin
                    if (pend_pop[i] && termq[i].size() > 0) void'(termq[i].pop_front());
                end
                while (rd_n < ld_n) begin
                    termq[ld_term[rd_n]].push_back(ld_data[rd_n]);
                    rd_n++;
                end
                pend_pop = bus.pop;
                for (int i = 0; i < NT; i++) begin
                    if (bus.pop[i]) pop_cnt[i]++;
                end
                if (!$onehot0(bus.pop)) multi_hot++;
                if (bus.pop != '0 && bus.pop == prev_pop) dbl_pop++;
                prev_pop = bus.pop;
                if (bus.out_valid && bus.out_ready) acc_q.push_back({bus.out_src, bus.out_data});
            end
            for (int i = 0; i < NT; i++) begin
                bus.pndng[i]    = (termq[i].size() > 0);
                bus.data_out[i] = (termq[i].size() > 0) ? termq[i][0] : '0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Wait (bounded) for a pop pulse; idx=-1 when none arrives.
    task automatic wait_grant(input int budget, output int idx, output logic [PW-1:0] d, output int cyc);
        bit found;
        idx   = -1;
        d     = '0;
        cyc   = 0;
        found = 0;
        for (int c = 0; c < budget && !found; c++) begin
            tick();
            if (bus.pop != '0) begin
                for (int i = 0; i < NT; i++) if (bus.pop[i]) idx = i;
                d     = bus.out_data;
                cyc   = c + 1;
                found = 1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int              idx;
        int              cyc;
        int              pops;
        int              unstable;
        int              others;
        logic [PW-1:0]   d;
        logic [IW+PW-1:0] a;
        logic [PW-1:0]   exp_d;

        reset         = 1'b1;
        bus.out_ready = 1'b0;
        tick(); tick(); tick();
        check_eq("rst_pop",   bus.pop,       0);
        check_eq("rst_valid", bus.out_valid, 0);
        check_eq("rst_data",  bus.out_data,  0);
        check_eq("rst_src",   bus.out_src,   0);
        check_eq("rst_busy",  bus.busy,      0);
        reset = 1'b0;
        tick();

        // Reset asserted while pop[3] is high.
        bus.out_ready = 1'b1;
        load(3, 40'h33);
        wait_grant(10, idx, d, cyc);
        check_eq("t1_grant", idx, 3);
        check_eq("t1_pop",   bus.pop, 16'h0008);
        reset = 1'b1;
        #1;
        check_eq("t1_rst_pop",   bus.pop,       0);
        check_eq("t1_rst_valid", bus.out_valid, 0);
        check_eq("t1_rst_busy",  bus.busy,      0);
        tick(); tick();
        reset = 1'b0;
        tick();
        // Pointer back at 0 picks 2 before 9 (a stale pointer of 4 would pick 9).
        load(2, 40'h22);
        load(9, 40'h99);
        wait_grant(10, idx, d, cyc);
        check_eq("t1_ptr0_grant", idx, 2);
        wait_grant(10, idx, d, cyc);
        check_eq("t1_next_grant", idx, 9);

        // Single packet on terminal 5.
        do_reset();
        load(5, 40'hA5_0000_0001);
        wait_grant(10, idx, d, cyc);
        check_eq("t2_grant", idx, 5);
        check_eq("t2_valid", bus.out_valid, 1);
        check_eq("t2_data",  bus.out_data, 40'hA5_0000_0001);
        check_eq("t2_src",   bus.out_src, 5);
        check_eq("t2_pop",   bus.pop, 16'h0020);
        check_eq("t2_busy0", bus.busy, 1);
        tick();
        check_eq("t2_pop_end", bus.pop, 0);
        check_eq("t2_busy1",   bus.busy, 1);
        check_eq("t2_acc",     bus.out_valid, 0);
        tick();
        check_eq("t2_idle",    bus.busy, 0);
        check_eq("t2_popcnt",  pop_cnt[5], 1);

        // All terminals pending: 0..15 then 0 again, three cycles apart.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NT; i++) load(i, 40'h30_0000_0000 | (r << 8) | i);
        for (int g = 0; g < 17; g++) begin
            wait_grant(10, idx, d, cyc);
            exp_d = 40'h30_0000_0000 | ((g / 16) << 8) | (g % 16);
            check_eq($sformatf("t3_src%0d", g),  idx, g % 16);
            check_eq($sformatf("t3_data%0d", g), d, exp_d);
            if (g > 0) check_eq($sformatf("t3_gap%0d", g), cyc, 3);
        end

        // Wrap from pointer 15 to 0.
        do_reset();
        load(14, 40'hE);
        wait_grant(10, idx, d, cyc);
        check_eq("t4_g14", idx, 14);
        tick(); tick();
        load(15, 40'hF);
        load(0,  40'h0A);
        wait_grant(10, idx, d, cyc);
        check_eq("t4_g15", idx, 15);
        wait_grant(10, idx, d, cyc);
        check_eq("t4_g0",   idx, 0);
        check_eq("t4_d0",   d, 40'h0A);
        check_eq("t4_gap",  cyc, 3);
        wait_grant(8, idx, d, cyc);
        check_eq("t4_none", idx, -1);

        // Backpressure for 10 cycles with a second packet waiting on terminal 2.
        do_reset();
        bus.out_ready = 1'b0;
        load(2, 40'h20_0000_0001);
        load(2, 40'h20_0000_0002);
        wait_grant(10, idx, d, cyc);
        check_eq("t5_grant", idx, 2);
        check_eq("t5_data",  d, 40'h20_0000_0001);
        pops     = 0;
        unstable = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.pop != '0) pops++;
            if (bus.out_data !== 40'h20_0000_0001 || bus.out_src !== 4'd2 || bus.out_valid !== 1'b1)
                unstable++;
        end
        check_eq("t5_nopop",  pops, 0);
        check_eq("t5_stable", unstable, 0);
`ifdef MESH_SCHED_STATS_EN
        check_eq("t5_stall",  bus.stat_stall, 10);
`endif
        bus.out_ready = 1'b1;
        tick();
        check_eq("t5_nb_valid", bus.out_valid, 1);
        check_eq("t5_nb_data",  bus.out_data, 40'h20_0000_0002);
        check_eq("t5_nb_pop",   bus.pop, 16'h0004);
        check_eq("t5_acc_n",    acc_q.size(), 1);
        a = (acc_q.size() > 0) ? acc_q[0] : '0;
        check_eq("t5_acc0",     a, {4'd2, 40'h20_0000_0001});
`ifdef MESH_SCHED_STATS_EN
        check_eq("t5_pops",     bus.stat_pops, 2);
`endif

        // Three packets on terminal 7, drained in order.
        do_reset();
        bus.out_ready = 1'b1;
        load(7, 40'h70_0000_00A1);
        load(7, 40'h70_0000_00A2);
        load(7, 40'h70_0000_00A3);
        for (int c = 0; c < 20; c++) tick();
        check_eq("t6_popcnt", pop_cnt[7], 3);
        others = 0;
        for (int i = 0; i < NT; i++) if (i != 7) others += pop_cnt[i];
        check_eq("t6_others", others, 0);
        check_eq("t6_acc_n",  acc_q.size(), 3);
        for (int k = 0; k < 3; k++) begin
            a = (acc_q.size() > k) ? acc_q[k] : '0;
            check_eq($sformatf("t6_acc%0d", k), a, {4'd7, 40'h70_0000_00A1 + 40'(k)});
        end
`ifdef MESH_SCHED_STATS_EN
        check_eq("t6_pops", bus.stat_pops, 3);
`endif

        check_eq("multi_hot_pop", multi_hot, 0);
        check_eq("double_pop",    dbl_pop,   0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mesh_term_pop_scheduler
`default_nettype wire
